// File: rtl/zigbee_chip_spreader.sv
// IEEE 802.15.4 O-QPSK symbol-to-chip spreader: maps 4-bit symbols to 32-chip PN
// sequences and serialises them at chip rate with an I/Q select, one-symbol skid buffer.
module zigbee_chip_spreader #(
   parameter logic [31:0] PN_SYM0   = 32'hD9C3522E,
   parameter logic [31:0] ODD_MASK  = 32'h55555555,
   parameter logic        IDLE_CHIP = 1'b0
) (
   input  logic       inClk,
   input  logic       inRst,
   input  logic       inChipEn,
   input  logic       inSymValid,
   input  logic [3:0] inSym,
   output logic       outSymReady,
   output logic       outChip,
   output logic       outChipValid,
   output logic       outChipSel,
   output logic       outBusy
);

   typedef enum logic {StIdle, StRun} state_t;

   state_t      state_q, state_d;
   logic [31:0] shift_q, shift_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        pend_valid_q, pend_valid_d;
   logic [3:0]  pend_sym_q, pend_sym_d;
   logic        accept;
   logic        last_chip;

   // Symbols 0..7 are right rotations of PN_SYM0 by 4*s; 8..15 add odd-chip inversion.
   function automatic logic [31:0] map_sym(input logic [3:0] s);
      logic [63:0] dbl;
      logic [4:0]  amt;
      logic [31:0] seq;
      amt = {s[2:0], 2'b00};
      dbl = {PN_SYM0, PN_SYM0} >> amt;
      seq = dbl[31:0];
      if (s[3]) seq = seq ^ ODD_MASK;
      return seq;
   endfunction

   assign accept    = inSymValid & ~pend_valid_q;
   assign last_chip = inChipEn & (cnt_q == 5'd31);

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      pend_valid_d = pend_valid_q;
      pend_sym_d   = pend_sym_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               shift_d = map_sym(inSym);
               cnt_d   = 5'd0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (last_chip) begin
               if (pend_valid_q) begin
                  shift_d      = map_sym(pend_sym_q);
                  cnt_d        = 5'd0;
                  pend_valid_d = 1'b0;
               end else if (accept) begin
                  // Bypass: new symbol goes straight to the shifter, pending stays empty.
                  shift_d = map_sym(inSym);
                  cnt_d   = 5'd0;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               if (inChipEn) begin
                  shift_d = {shift_q[30:0], 1'b0};
                  cnt_d   = cnt_q + 5'd1;
               end
               if (accept) begin
                  pend_valid_d = 1'b1;
                  pend_sym_d   = inSym;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) begin
         state_q      <= StIdle;
         shift_q      <= 32'd0;
         cnt_q        <= 5'd0;
         pend_valid_q <= 1'b0;
         pend_sym_q   <= 4'd0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_sym_q   <= pend_sym_d;
      end
   end

   assign outChipValid = (state_q == StRun);
   assign outChip      = outChipValid ? shift_q[31] : IDLE_CHIP;
   assign outChipSel   = outChipValid ? cnt_q[0] : 1'b0;
   assign outBusy      = outChipValid | pend_valid_q;
   assign outSymReady  = ~pend_valid_q;

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Self-checking bench for zigbee_chip_spreader: chip-queue reference model checked every cycle,
// plus directed scenarios (reset, single symbols, streaming, bypass, stall, I/Q demux).
module tb_zigbee_chip_spreader;

   logic       clk = 1'b0;
   logic       rst;
   logic       chip_en;
   logic       sym_valid;
   logic [3:0] sym;
   logic       sym_ready;
   logic       chip;
   logic       chip_valid;
   logic       chip_sel;
   logic       busy;

   int          checks = 0;
   int          failures = 0;
   bit          exp_q[$];
   logic [31:0] cap;
   int          cap_cnt;
   logic [15:0] dm_i;
   logic [15:0] dm_q;

   zigbee_chip_spreader dut (
      .inClk        (clk),
      .inRst        (rst),
      .inChipEn     (chip_en),
      .inSymValid   (sym_valid),
      .inSym        (sym),
      .outSymReady  (sym_ready),
      .outChip      (chip),
      .outChipValid (chip_valid),
      .outChipSel   (chip_sel),
      .outBusy      (busy)
   );

   always #5 clk = ~clk;

   // Chip k of symbol s: PN chip at (k - 4*(s mod 8)) mod 32, odd chips inverted for s >= 8.
   function automatic bit exp_chip(input int s, input int k);
      bit [31:0] pn;
      int        pos;
      bit        c;
      pn  = 32'hD9C3522E;
      pos = (((k - 4 * (s % 8)) % 32) + 32) % 32;
      c   = pn[31 - pos];
      if (s >= 8 && (k % 2) == 1) c = ~c;
      return c;
   endfunction

   function automatic logic [31:0] exp_word(input int s);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 32; k++) w = {w[30:0], logic'(exp_chip(s, k))};
      return w;
   endfunction

   task automatic chk(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_outs();
      int n;
      n = exp_q.size();
      chk("chip_valid", chip_valid, logic'(n > 0));
      chk("chip", chip, (n > 0) ? logic'(exp_q[0]) : 1'b0);
      chk("chip_sel", chip_sel, (n > 0) ? logic'(((32 - n % 32) % 32) % 2) : 1'b0);
      chk("sym_ready", sym_ready, logic'((n + 31) / 32 < 2));
      chk("busy", busy, logic'(n > 0));
   endtask

   // One clock: model update at the edge, output check on the falling edge.
   task automatic step(output bit acc);
      int         n;
      bit         cons;
      logic [3:0] s;
      n    = exp_q.size();
      acc  = sym_valid && ((n + 31) / 32 < 2);
      cons = chip_en && (n > 0);
      s    = sym;
      if (chip_en && chip_valid) begin
         cap = {cap[30:0], chip};
         cap_cnt++;
         if (chip_sel) dm_q = {dm_q[14:0], chip};
         else          dm_i = {dm_i[14:0], chip};
      end
      @(posedge clk);
      if (cons) void'(exp_q.pop_front());
      if (acc) for (int k = 0; k < 32; k++) exp_q.push_back(exp_chip(int'(s), k));
      @(negedge clk);
      check_outs();
   endtask

   task automatic drain(input int period);
      bit a;
      sym_valid = 1'b0;
      for (int k = 0; k < 40 * period + 10; k++) begin
         chip_en = (k % period == period - 1);
         step(a);
         if (exp_q.size() == 0) break;
      end
      chip_en = 1'b0;
      chk("drain_done", logic'(exp_q.size() == 0), 1'b1);
   endtask

   task automatic send_and_drain(input logic [3:0] s, input int period, output logic [31:0] word);
      bit a;
      sym = s; sym_valid = 1'b1; chip_en = 1'b0;
      step(a);
      cap = '0;
      drain(period);
      word = cap;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      exp_q.delete();
      check_outs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_outs();
   endtask

   initial begin
      logic [31:0] w;
      logic [15:0] ei, eq;
      logic        hold_chip, hold_sel;
      bit          a;
      bit          saw_not_ready;
      int          nxt;

      rst = 1'b1; chip_en = 1'b0; sym_valid = 1'b0; sym = 4'd0;
      cap = '0; cap_cnt = 0; dm_i = '0; dm_q = '0;
      #1;
      check_outs();
      @(negedge clk);
      rst = 1'b0;
      check_outs();

      // Single symbols, MSB-first word capture
      send_and_drain(4'd0, 4, w);
      chk32("t2_sym0", w, 32'hD9C3522E);
      send_and_drain(4'd1, 3, w);
      chk32("t3_sym1", w, 32'hED9C3522);
      send_and_drain(4'd8, 2, w);
      chk32("t3_sym8", w, 32'h8C96077B);

      // Streaming 0..15 with valid held high
      nxt = 0; sym = 4'd0; sym_valid = 1'b1; cap_cnt = 0; saw_not_ready = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         chip_en = (k % 2 == 1);
         step(a);
         if (!sym_ready) saw_not_ready = 1'b1;
         if (a) begin
            nxt++;
            if (nxt == 16) sym_valid = 1'b0;
            else sym = 4'(nxt);
         end
         if (nxt == 16 && exp_q.size() == 0) break;
      end
      chip_en = 1'b0;
      chk32("t4_chip_count", 32'(cap_cnt), 32'd512);
      chk("t4_ready_dropped", saw_not_ready, 1'b1);

      // Accept on the chip-31 strobe with pending empty
      sym = 4'd3; sym_valid = 1'b1; chip_en = 1'b0;
      step(a);
      sym_valid = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (exp_q.size() == 1) begin
            chip_en = 1'b1; sym = 4'd5; sym_valid = 1'b1;
            step(a);
            sym_valid = 1'b0; chip_en = 1'b0;
            chk("t5_bypass_c0", chip, logic'(exp_chip(5, 0)));
            chk("t5_sel0", chip_sel, 1'b0);
            chk("t5_pend_empty", sym_ready, 1'b1);
            break;
         end
         chip_en = (k % 3 == 2);
         step(a);
      end
      drain(2);

      // Stall mid-symbol, then resume; demux I/Q split
      dm_i = '0; dm_q = '0;
      sym = 4'd10; sym_valid = 1'b1; chip_en = 1'b0;
      step(a);
      sym_valid = 1'b0;
      for (int k = 0; k < 22; k++) begin
         chip_en = (k % 2 == 1);
         step(a);
      end
      chip_en = 1'b0;
      hold_chip = chip; hold_sel = chip_sel;
      for (int k = 0; k < 100; k++) step(a);
      chk("t6_hold_chip", chip, hold_chip);
      chk("t6_hold_sel", chip_sel, hold_sel);
      drain(2);
      ei = '0; eq = '0;
      for (int k = 0; k < 32; k++) begin
         if (k % 2 == 0) ei = {ei[14:0], logic'(exp_chip(10, k))};
         else            eq = {eq[14:0], logic'(exp_chip(10, k))};
      end
      chk32("t6_demux_i", {16'd0, dm_i}, {16'd0, ei});
      chk32("t6_demux_q", {16'd0, dm_q}, {16'd0, eq});

      // Random traffic; symbol only changes when not stalled
      sym_valid = 1'b0;
      for (int k = 0; k < 600; k++) begin
         chip_en = ($urandom_range(0, 2) == 0);
         if (!sym_valid && $urandom_range(0, 3) == 0) begin
            sym = 4'($urandom_range(0, 15));
            sym_valid = 1'b1;
         end
         step(a);
         if (a) sym_valid = 1'b0;
      end
      sym_valid = 1'b0;

      // Reset mid-symbol
      sym = 4'd12; sym_valid = 1'b1; chip_en = 1'b0;
      step(a);
      step(a);
      sym_valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
         chip_en = 1'b1;
         step(a);
      end
      chip_en = 1'b0;
      do_reset();

      send_and_drain(4'd7, 1, w);
      chk32("after_reset_sym7", w, exp_word(7));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
